// File: rtl/avr_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : avr_tx_scheduler_if
// Description : Requester and serial-transmitter signal bundle for the AVR TX
//               scheduler. master = scheduler side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface avr_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic                   cclk_ready;
    logic                   tx_block;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ack;
    logic [7:0]             tx_data;
    logic                   new_tx_data;
    logic                   tx_busy;
    logic                   active;
    logic [ID_W-1:0]        grant_id;
    logic                   tx_timeout;

    modport master (
        input  cclk_ready, tx_block, req_valid, req_data, tx_busy,
        output req_ack, tx_data, new_tx_data, active, grant_id, tx_timeout
    );

    modport slave (
        output cclk_ready, tx_block, req_valid, req_data, tx_busy,
        input  req_ack, tx_data, new_tx_data, active, grant_id, tx_timeout
    );
endinterface
`default_nettype wire

// File: rtl/avr_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : avr_tx_scheduler
// Description : Round-robin arbiter sharing the AVR serial TX path among
//               NUM_REQ byte producers. Optional watchdog: AVR_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module avr_tx_scheduler #(
    parameter int NUM_REQ           = 4,
    parameter int ID_W              = 2,
    parameter int BLOCK_SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    avr_tx_scheduler_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ID_W:0]   c_num_req  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_req = ID_W'(NUM_REQ - 1);

    state_t                     r_state, w_state_next;
    logic [ID_W-1:0]            r_rr_ptr, w_rr_ptr_next;
    logic [BLOCK_SYNC_STAGES-1:0] r_blk_sync;
    logic                       w_blk_s;

    logic [NUM_REQ-1:0]         r_req_ack, w_req_ack_next;
    logic [7:0]                 r_tx_data, w_tx_data_next;
    logic                       r_new_tx_data, w_new_tx_data_next;
    logic                       r_active, w_active_next;
    logic [ID_W-1:0]            r_grant_id, w_grant_id_next;
    logic                       r_tx_timeout, w_tx_timeout_next;

`ifdef AVR_TX_TIMEOUT_EN
    logic [4:0]                 r_wd_cnt, w_wd_cnt_next;
`endif

    logic [2*NUM_REQ-1:0]       w_valid_2x;
    logic [NUM_REQ-1:0]         w_valid_rot;
    logic [ID_W-1:0]            w_offset;
    logic [ID_W:0]              w_win_sum;
    logic [ID_W-1:0]            w_winner;
    logic [NUM_REQ-1:0]         w_win_onehot;
    logic [7:0]                 w_win_data;
    logic [ID_W-1:0]            w_ptr_inc;
    logic                       w_grant;

    // tx_block is asynchronous; the chain powers up "blocked" so no grant
    // can slip out before the line has been sampled cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_sync <= '1;
        end else begin
            r_blk_sync <= {r_blk_sync[BLOCK_SYNC_STAGES-2:0], bus.tx_block};
        end
    end

    assign w_blk_s = r_blk_sync[BLOCK_SYNC_STAGES-1];

    // Rotate the request vector so index 0 is the rr_ptr position, then take
    // the lowest set bit and map the offset back to an absolute index.
    assign w_valid_2x  = {bus.req_valid, bus.req_valid};
    assign w_valid_rot = w_valid_2x[r_rr_ptr +: NUM_REQ];

    always_comb begin
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_valid_rot[i]) begin
                w_offset = ID_W'(i);
            end
        end
    end

    assign w_win_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_winner  = (w_win_sum >= c_num_req) ? ID_W'(w_win_sum - c_num_req)
                                                : w_win_sum[ID_W-1:0];

    always_comb begin
        w_win_data   = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_win_data      = bus.req_data[8*i +: 8];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_grant_id == c_last_req) ? '0 : r_grant_id + ID_W'(1);
    assign w_grant   = bus.cclk_ready && !w_blk_s && (|bus.req_valid);

    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_req_ack_next     = '0;
        w_new_tx_data_next = 1'b0;
        w_active_next      = r_active;
        w_grant_id_next    = r_grant_id;
        w_tx_data_next     = r_tx_data;
        w_tx_timeout_next  = 1'b0;
`ifdef AVR_TX_TIMEOUT_EN
        w_wd_cnt_next      = r_wd_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_tx_data_next     = w_win_data;
                    w_grant_id_next    = w_winner;
                    w_req_ack_next     = w_win_onehot;
                    w_new_tx_data_next = 1'b1;
                    w_active_next      = 1'b1;
                    w_state_next       = S_WAIT_BUSY;
`ifdef AVR_TX_TIMEOUT_EN
                    w_wd_cnt_next      = '0;
`endif
                end
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end
`ifdef AVR_TX_TIMEOUT_EN
                else if (r_wd_cnt == 5'd15) begin
                    // Sixteenth idle cycle: give up on this byte and move on.
                    w_state_next      = S_IDLE;
                    w_active_next     = 1'b0;
                    w_rr_ptr_next     = w_ptr_inc;
                    w_tx_timeout_next = 1'b1;
                end else begin
                    w_wd_cnt_next = r_wd_cnt + 5'd1;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_state_next  = S_IDLE;
                    w_active_next = 1'b0;
                    w_rr_ptr_next = w_ptr_inc;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_req_ack     <= '0;
            r_tx_data     <= '0;
            r_new_tx_data <= 1'b0;
            r_active      <= 1'b0;
            r_grant_id    <= '0;
            r_tx_timeout  <= 1'b0;
`ifdef AVR_TX_TIMEOUT_EN
            r_wd_cnt      <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_req_ack     <= w_req_ack_next;
            r_tx_data     <= w_tx_data_next;
            r_new_tx_data <= w_new_tx_data_next;
            r_active      <= w_active_next;
            r_grant_id    <= w_grant_id_next;
            r_tx_timeout  <= w_tx_timeout_next;
`ifdef AVR_TX_TIMEOUT_EN
            r_wd_cnt      <= w_wd_cnt_next;
`endif
        end
    end

    assign bus.req_ack     = r_req_ack;
    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = r_new_tx_data;
    assign bus.active      = r_active;
    assign bus.grant_id    = r_grant_id;
    assign bus.tx_timeout  = r_tx_timeout;

endmodule
`default_nettype wire
